// File: rtl/pkt_formatter_if.sv
// pkt_formatter_if: bus bundle between the channel arbiter, the packet
// formatter and the downstream consumer.
//   master modport : formatter side (drives f2a_* and fmt_* outputs)
//   slave modport  : environment side (arbiter/slave and consumer)
// Signals:
//   f2a_id_req_o / f2a_ack_o            ID request pulse and slave pop strobe
//   a2f_val_i / a2f_id_i / a2f_data_i   selected slave byte, granted ID
//   a2f_pkglen_sel_i                    package length code
//   fmt_req_o / fmt_grant_i             downstream bus request / grant
//   fmt_ready_i / fmt_val_o             output byte handshake
//   fmt_start_o / fmt_end_o             frame markers
//   fmt_id_o / fmt_data_o               packet channel ID and byte
//   fmt_parity_o                        only when FMT_PARITY_EN is defined
interface pkt_formatter_if #(
  parameter int unsigned DATA_W = 8
);
  logic              f2a_id_req_o;
  logic              f2a_ack_o;
  logic              a2f_val_i;
  logic [1:0]        a2f_id_i;
  logic [DATA_W-1:0] a2f_data_i;
  logic [2:0]        a2f_pkglen_sel_i;
  logic              fmt_req_o;
  logic              fmt_grant_i;
  logic              fmt_ready_i;
  logic              fmt_val_o;
  logic              fmt_start_o;
  logic              fmt_end_o;
  logic [1:0]        fmt_id_o;
  logic [DATA_W-1:0] fmt_data_o;
`ifdef FMT_PARITY_EN
  logic              fmt_parity_o;
`endif

  modport master (
    input  a2f_val_i, a2f_id_i, a2f_data_i, a2f_pkglen_sel_i,
    input  fmt_grant_i, fmt_ready_i,
`ifdef FMT_PARITY_EN
    output fmt_parity_o,
`endif
    output f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_val_o,
    output fmt_start_o, fmt_end_o, fmt_id_o, fmt_data_o
  );

  modport slave (
    output a2f_val_i, a2f_id_i, a2f_data_i, a2f_pkglen_sel_i,
    output fmt_grant_i, fmt_ready_i,
`ifdef FMT_PARITY_EN
    input  fmt_parity_o,
`endif
    input  f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_val_o,
    input  fmt_start_o, fmt_end_o, fmt_id_o, fmt_data_o
  );
endinterface

// File: rtl/pkt_formatter.sv
// pkt_formatter: requests a channel ID from the arbiter, latches the granted
// ID and decoded packet length, pops exactly that many bytes from the selected
// slave and emits them as a framed, registered byte stream downstream.
// Ports:
//   clk_i   clock
//   rstn_i  asynchronous active-low reset
//   bus     pkt_formatter_if.master (arbiter, slave and consumer signals)
// Parameters:
//   PKT_GAP  idle cycles between end of packet and next ID request (0..15)
//   DATA_W   byte width, fixed at 8
// Optional feature: define FMT_PARITY_EN to add fmt_parity_o, the XOR of the
// registered output byte, registered alongside it.
module pkt_formatter #(
  parameter int unsigned PKT_GAP = 2,
  parameter int unsigned DATA_W  = 8
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  pkt_formatter_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_ARB     = 3'd3,
    ST_SEND    = 3'd4,
    ST_DRAIN   = 3'd5
  } state_t;

  localparam logic       GAP_ZERO = (PKT_GAP == 32'd0);
  localparam logic [3:0] GAP_LAST = GAP_ZERO ? 4'd0 : 4'(PKT_GAP - 32'd1);

  state_t            state_r;
  state_t            state_s;
  logic [3:0]        gap_cnt_r;
  logic              gap_done_s;
  logic [5:0]        rem_r;
  logic              first_r;
  logic [1:0]        id_r;
  logic              id_req_r;
  logic              req_r;
  logic              ack_s;
  logic              val_r;
  logic              start_r;
  logic              end_r;
  logic [DATA_W-1:0] data_r;
`ifdef FMT_PARITY_EN
  logic              parity_r;
`endif

  // Codes 1xx saturate at 32 so the 6-bit counter never needs more.
  function automatic logic [5:0] len_decode(input logic [2:0] sel);
    case (sel)
      3'b000:  len_decode = 6'd4;
      3'b001:  len_decode = 6'd8;
      3'b010:  len_decode = 6'd16;
      default: len_decode = 6'd32;
    endcase
  endfunction

`ifdef FMT_PARITY_EN
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    even_parity = ^d;
  endfunction
`endif

  assign gap_done_s = GAP_ZERO | (gap_cnt_r == GAP_LAST);

  // Next-state and slave pop strobe; the pop is combinational so a byte can
  // be accepted in the same cycle the output register is drained.
  always_comb begin
    state_s = state_r;
    ack_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (gap_done_s) state_s = ST_REQ;
        else            state_s = ST_IDLE;
      end
      ST_REQ: begin
        state_s = ST_WAIT_ID;
      end
      ST_WAIT_ID: begin
        if (bus.a2f_id_i == 2'b11) state_s = ST_IDLE;
        else                       state_s = ST_ARB;
      end
      ST_ARB: begin
        if (bus.fmt_grant_i) state_s = ST_SEND;
        else                 state_s = ST_ARB;
      end
      ST_SEND: begin
        ack_s = bus.a2f_val_i & (~val_r | bus.fmt_ready_i) & (rem_r != 6'd0);
        if (ack_s && (rem_r == 6'd1)) state_s = ST_DRAIN;
        else                          state_s = ST_SEND;
      end
      ST_DRAIN: begin
        if (!val_r || (bus.fmt_ready_i && end_r)) state_s = ST_IDLE;
        else                                      state_s = ST_DRAIN;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register plus the request strobes, registered from the next state
  // so they line up exactly with the state they belong to.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r  <= ST_IDLE;
      id_req_r <= 1'b0;
      req_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      id_req_r <= (state_s == ST_REQ);
      req_r    <= (state_s == ST_ARB) || (state_s == ST_SEND) || (state_s == ST_DRAIN);
    end
  end

  // Inter-packet gap counter; only runs while idle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      gap_cnt_r <= 4'd0;
    end else if ((state_r == ST_IDLE) && !gap_done_s) begin
      gap_cnt_r <= gap_cnt_r + 4'd1;
    end else begin
      gap_cnt_r <= 4'd0;
    end
  end

  // Packet context: ID and length captured once in WAIT_ID, remaining count
  // and first-byte flag advanced by each transfer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      id_r    <= 2'b11;
      rem_r   <= 6'd0;
      first_r <= 1'b0;
    end else if ((state_r == ST_WAIT_ID) && (bus.a2f_id_i != 2'b11)) begin
      id_r    <= bus.a2f_id_i;
      rem_r   <= len_decode(bus.a2f_pkglen_sel_i);
      first_r <= 1'b1;
    end else if (ack_s) begin
      rem_r   <= rem_r - 6'd1;
      first_r <= 1'b0;
    end else begin
      rem_r   <= rem_r;
      first_r <= first_r;
    end
  end

  // Output register: load on transfer, clear on pop, otherwise hold.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      val_r    <= 1'b0;
      start_r  <= 1'b0;
      end_r    <= 1'b0;
      data_r   <= '0;
`ifdef FMT_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else if (ack_s) begin
      val_r    <= 1'b1;
      start_r  <= first_r;
      end_r    <= (rem_r == 6'd1);
      data_r   <= bus.a2f_data_i;
`ifdef FMT_PARITY_EN
      parity_r <= even_parity(bus.a2f_data_i);
`endif
    end else if (bus.fmt_ready_i) begin
      val_r    <= 1'b0;
      start_r  <= 1'b0;
      end_r    <= 1'b0;
    end else begin
      val_r    <= val_r;
      start_r  <= start_r;
      end_r    <= end_r;
    end
  end

  assign bus.f2a_id_req_o = id_req_r;
  assign bus.f2a_ack_o    = ack_s;
  assign bus.fmt_req_o    = req_r;
  assign bus.fmt_val_o    = val_r;
  assign bus.fmt_start_o  = start_r;
  assign bus.fmt_end_o    = end_r;
  assign bus.fmt_id_o     = id_r;
  assign bus.fmt_data_o   = data_r;
`ifdef FMT_PARITY_EN
  assign bus.fmt_parity_o = parity_r;
`endif

endmodule

// File: tb/tb_pkt_formatter.sv
// tb_pkt_formatter: directed sequence of packets with randomized data, slave
// valid, downstream ready and grant. A scoreboard of expected bytes per packet
// (length computed from the length code) checks order, framing, hold under
// backpressure, ack count and request timing.
module tb_pkt_formatter;
  localparam int unsigned PKT_GAP = 2;

  logic clk_i = 1'b0;
  logic rstn_i;

  pkt_formatter_if bus();

  pkt_formatter #(.PKT_GAP(PKT_GAP), .DATA_W(8)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] slave_q[$];
  logic [7:0] exp_q[$];
  int exp_len, stop_len, taken, acks, starts, ends;
  int first_take_cyc, last_take_cyc;
  int ready_mode, val_mode, grant_mode, stall_left, stall_at;
  int idreq_cnt, last_idreq_cyc;
  bit chk_period, fmtreq_seen, scramble, hold_pend, end_taken_prev;
  logic [7:0] hold_data;
  logic hold_start, hold_end;
  logic [1:0] exp_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int len_of(input logic [2:0] sel);
    return sel[2] ? 32 : (4 << sel[1:0]);
  endfunction

  task automatic drive();
    logic v;
    case (val_mode)
      0:       v = 1'b1;
      default: v = ($urandom_range(0, 3) != 0);
    endcase
    if (stall_left > 0 && acks >= stall_at) begin
      v = 1'b0;
      stall_left--;
    end
    bus.a2f_val_i  = v && (slave_q.size() > 0);
    bus.a2f_data_i = (slave_q.size() > 0) ? slave_q[0] : 8'($urandom);
    case (ready_mode)
      0:       bus.fmt_ready_i = 1'b1;
      1:       bus.fmt_ready_i = ~bus.fmt_ready_i;
      default: bus.fmt_ready_i = 1'($urandom_range(0, 1));
    endcase
    bus.fmt_grant_i = (grant_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  // One clock: observe at negedge, update models, drive after posedge.
  task automatic cycle();
    logic ack_s, val_s, rdy_s;
    logic [7:0] exp_b;
    @(negedge clk_i);
    cyc++;
    ack_s = bus.f2a_ack_o;
    val_s = bus.fmt_val_o;
    rdy_s = bus.fmt_ready_i;
    if (bus.f2a_id_req_o) begin
      if (chk_period && idreq_cnt > 0) check("id_req_period", cyc - last_idreq_cyc, PKT_GAP + 2);
      idreq_cnt++;
      last_idreq_cyc = cyc;
    end
    if (bus.fmt_req_o) fmtreq_seen = 1'b1;
    if (ack_s) begin
      check("ack_needs_val", bus.a2f_val_i, 1'b1);
      check("ack_when_blocked", val_s & ~rdy_s, 1'b0);
    end
    if (hold_pend) begin
      check("hold_val", val_s, 1'b1);
      check("hold_data", bus.fmt_data_o, hold_data);
      check("hold_start", bus.fmt_start_o, hold_start);
      check("hold_end", bus.fmt_end_o, hold_end);
    end
    if (end_taken_prev) check("req_drop", bus.fmt_req_o, 1'b0);
    end_taken_prev = 1'b0;
`ifdef FMT_PARITY_EN
    check("parity", bus.fmt_parity_o, ^bus.fmt_data_o);
`endif
    if (val_s) check("fmt_id", bus.fmt_id_o, exp_id);
    if (val_s && rdy_s) begin
      check("no_extra_byte", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        check("data", bus.fmt_data_o, exp_b);
        check("start", bus.fmt_start_o, (taken == 0));
        check("end", bus.fmt_end_o, (taken == exp_len - 1));
        if (bus.fmt_start_o) starts++;
        if (bus.fmt_end_o) begin
          ends++;
          end_taken_prev = 1'b1;
        end
        if (taken == 0) first_take_cyc = cyc;
        last_take_cyc = cyc;
        taken++;
      end
    end
    hold_pend  = val_s & ~rdy_s;
    hold_data  = bus.fmt_data_o;
    hold_start = bus.fmt_start_o;
    hold_end   = bus.fmt_end_o;
    @(posedge clk_i);
    #1;
    if (ack_s) begin
      if (slave_q.size() > 0) void'(slave_q.pop_front());
      acks++;
    end
    if (scramble && fmtreq_seen) begin
      bus.a2f_id_i         = 2'($urandom_range(0, 2));
      bus.a2f_pkglen_sel_i = 3'($urandom);
    end
    drive();
  endtask

  task automatic run_packet(input logic [1:0] id, input logic [2:0] sel, input int rmode,
                            input int vmode, input int gmode, input int stall_n,
                            input bit fixed, input logic [7:0] base, input int stop_at,
                            input bit scr);
    logic [7:0] b;
    exp_len = len_of(sel);
    stop_len = (stop_at > 0) ? stop_at : exp_len;
    taken = 0; acks = 0; starts = 0; ends = 0; idreq_cnt = 0;
    fmtreq_seen = 1'b0; scramble = scr; exp_id = id;
    for (int i = 0; i < exp_len; i++) begin
      b = fixed ? 8'(base + 8'(i)) : 8'($urandom);
      slave_q.push_back(b);
      exp_q.push_back(b);
    end
    ready_mode = rmode; val_mode = vmode; grant_mode = gmode;
    stall_left = stall_n; stall_at = 3;
    bus.a2f_id_i = id;
    bus.a2f_pkglen_sel_i = sel;
    drive();
    for (int n = 0; n < 1000 && taken < stop_len; n++) cycle();
    check("pkt_taken", taken, stop_len);
    if (stop_len == exp_len) begin
      cycle();
      scramble = 1'b0;
      bus.a2f_id_i = 2'b11;
      check("ack_count", acks, exp_len);
      check("start_count", starts, 1);
      check("end_count", ends, 1);
      check("id_req_seen", (idreq_cnt > 0), 1'b1);
      check("fmt_id_latched", bus.fmt_id_o, id);
      slave_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_id_req"}, bus.f2a_id_req_o, 1'b0);
    check({tag, "_ack"}, bus.f2a_ack_o, 1'b0);
    check({tag, "_fmt_req"}, bus.fmt_req_o, 1'b0);
    check({tag, "_val"}, bus.fmt_val_o, 1'b0);
    check({tag, "_start"}, bus.fmt_start_o, 1'b0);
    check({tag, "_end"}, bus.fmt_end_o, 1'b0);
    check({tag, "_id"}, bus.fmt_id_o, 2'b11);
    check({tag, "_data"}, bus.fmt_data_o, 8'h00);
`ifdef FMT_PARITY_EN
    check({tag, "_parity"}, bus.fmt_parity_o, 1'b0);
`endif
  endtask

  initial begin
    logic [2:0] sel;
    bus.a2f_val_i = 1'b0; bus.a2f_id_i = 2'b11; bus.a2f_data_i = 8'h00;
    bus.a2f_pkglen_sel_i = 3'b111; bus.fmt_grant_i = 1'b1; bus.fmt_ready_i = 1'b1;
    ready_mode = 0; val_mode = 0; grant_mode = 0; stall_left = 0; stall_at = 0;
    chk_period = 1'b0; scramble = 1'b0; hold_pend = 1'b0; end_taken_prev = 1'b0;
    exp_id = 2'b11; exp_len = 0; taken = 0; acks = 0;
    rstn_i = 1'b1;
    #3 rstn_i = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    drive();

    // No requests pending: periodic ID requests only.
    idreq_cnt = 0; acks = 0; fmtreq_seen = 1'b0; chk_period = 1'b1;
    for (int n = 0; n < 30; n++) cycle();
    chk_period = 1'b0;
    check("idle_id_req_count", (idreq_cnt >= 6), 1'b1);
    check("idle_fmt_req", fmtreq_seen, 1'b0);
    check("idle_acks", acks, 0);

    // Single 4-byte packet 0x11..0x14, full throughput.
    run_packet(2'd0, 3'b000, 0, 0, 0, 0, 1'b1, 8'h11, 0, 1'b0);
    check("t1_consecutive", last_take_cyc - first_take_cyc, 3);

    // 32 bytes on slave2 with ready toggling.
    run_packet(2'd2, 3'b011, 1, 0, 0, 0, 1'b0, 8'h00, 0, 1'b0);
    // Code 101 treated as 32, random ready, inputs scrambled after capture.
    run_packet(2'd1, 3'b101, 2, 1, 0, 0, 1'b0, 8'h00, 0, 1'b1);
    // 8-byte packet with a 5-cycle slave stall after byte 3.
    run_packet(2'd1, 3'b001, 0, 0, 0, 5, 1'b0, 8'h00, 0, 1'b0);

    // Random packets with random valid, ready and grant.
    for (int p = 0; p < 6; p++) begin
      sel = 3'($urandom);
      run_packet(2'($urandom_range(0, 2)), sel, 2, 1, 1, 0, 1'b0, 8'h00, 0, 1'b1);
    end

    // Reset after byte 3 of a 16-byte packet.
    run_packet(2'd0, 3'b010, 0, 0, 0, 0, 1'b1, 8'h40, 3, 1'b0);
    @(posedge clk_i);
    #2 rstn_i = 1'b0;
    #1 check_reset_outputs("midpkt_reset");
    slave_q.delete(); exp_q.delete();
    hold_pend = 1'b0; end_taken_prev = 1'b0;
    bus.a2f_id_i = 2'b11; bus.a2f_val_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    drive();
    // Recovery packet starting with 0x07 (parity 1 when enabled).
    run_packet(2'd1, 3'b000, 0, 0, 0, 0, 1'b1, 8'h07, 0, 1'b0);
    check("recovery_first_cycle_valid", (first_take_cyc > 0), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
